// File: rtl/display_scheduler.sv
// display_scheduler: shares one two-digit 7-segment display between three
// requesters (score, level, status/timer) using round-robin ownership with a
// minimum hold time, a blank gap between owners, and per-owner blinking.
module display_scheduler #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int BLINK_HALF  = 6_250_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [2:0] i_Req,
  input  logic [6:0] i_Value0,
  input  logic [6:0] i_Value1,
  input  logic [6:0] i_Value2,
  input  logic [2:0] i_Blink,
  output logic [2:0] o_Grant,
  output logic [6:0] o_Counter,
  output logic       o_Blank,
  output logic       o_Busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          blink_prev, blink_prev_next;
  logic [1:0]    last, last_next;
  logic [2:0]    grant_next;
  logic [6:0]    counter_next;
  logic          blank_next;
  logic          busy_next;

  logic [1:0]    winner;
  logic [2:0]    winner_mask;
  logic [2:0]    owner_mask;
  logic          owner_req;
  logic          owner_blink;
  logic          other_pending;
  logic          hold_expired;
  logic          gap_last;
  logic          start_show;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [6:0] value_of(input logic [1:0] idx, input logic [6:0] v0,
                                          input logic [6:0] v1, input logic [6:0] v2);
    case (idx)
      2'd1:    return v1;
      2'd2:    return v2;
      default: return v0;
    endcase
  endfunction

  // Search starts one past the last owner and wraps, so every requester gets a turn.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = 2'((32'(ptr) + k) % 3);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Owner-relative views of the request/blink vectors; last is the owner while in SHOW.
  always_comb begin
    winner        = rr_pick(i_Req, last);
    winner_mask   = 3'(3'b001 << winner);
    owner_mask    = 3'(3'b001 << last);
    owner_req     = |(i_Req & owner_mask);
    owner_blink   = |(i_Blink & owner_mask);
    other_pending = |(i_Req & ~owner_mask);
    hold_expired  = (hold_cnt == HW'(HOLD_CYCLES - 1));
    gap_last      = (gap_cnt == GW'(GAP_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: the owner is only reconsidered once its hold time has expired.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (|i_Req) state_next = SHOW;
      SHOW: begin
        if (hold_expired) begin
          if (other_pending)  state_next = GAP;
          else if (owner_req) state_next = SHOW;
          else                state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_last) state_next = (|i_Req) ? SHOW : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_show = (state != SHOW) && (state_next == SHOW);

  // Output and counter next values, registered below so every output is a flop.
  always_comb begin
    grant_next      = o_Grant;
    counter_next    = o_Counter;
    blank_next      = o_Blank;
    busy_next       = (state_next != IDLE);
    hold_next       = hold_cnt;
    gap_next        = gap_cnt;
    blink_cnt_next  = blink_cnt;
    blink_prev_next = blink_prev;
    last_next       = last;
    if (start_show) begin
      grant_next      = winner_mask;
      last_next       = winner;
      hold_next       = '0;
      counter_next    = sat99(value_of(winner, i_Value0, i_Value1, i_Value2));
      blank_next      = 1'b0;
      blink_cnt_next  = '0;
      blink_prev_next = |(i_Blink & winner_mask);
    end else if (state_next == IDLE) begin
      grant_next = '0;
      blank_next = 1'b1;
    end else if (state_next == GAP) begin
      grant_next = '0;
      blank_next = 1'b1;
      gap_next   = (state == GAP) ? gap_cnt + GW'(1) : '0;
    end else begin
      if (!hold_expired) hold_next = hold_cnt + HW'(1);
      if (owner_req) counter_next = sat99(value_of(last, i_Value0, i_Value1, i_Value2));
      // A change of the owner's blink enable restarts the phase as visible.
      if (owner_blink != blink_prev) begin
        blink_prev_next = owner_blink;
        blink_cnt_next  = '0;
        blank_next      = 1'b0;
      end else if (owner_blink) begin
        if (blink_cnt == BW'(BLINK_HALF - 1)) begin
          blink_cnt_next = '0;
          blank_next     = ~o_Blank;
        end else begin
          blink_cnt_next = blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt_next = '0;
        blank_next     = 1'b0;
      end
    end
  end

  // Output and counter registers; last starts at 2 so requester 0 wins first.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Grant    <= '0;
      o_Counter  <= '0;
      o_Blank    <= 1'b1;
      o_Busy     <= 1'b0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      blink_cnt  <= '0;
      blink_prev <= 1'b0;
      last       <= 2'd2;
    end else begin
      o_Grant    <= grant_next;
      o_Counter  <= counter_next;
      o_Blank    <= blank_next;
      o_Busy     <= busy_next;
      hold_cnt   <= hold_next;
      gap_cnt    <= gap_next;
      blink_cnt  <= blink_cnt_next;
      blink_prev <= blink_prev_next;
      last       <= last_next;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural ownership model.
module tb_display_scheduler;

  localparam int HOLD = 8;
  localparam int GAP  = 2;
  localparam int BH   = 3;

  logic       i_Clk;
  logic       i_Rst_n;
  logic [2:0] i_Req;
  logic [6:0] i_Value0, i_Value1, i_Value2;
  logic [2:0] i_Blink;
  logic [2:0] o_Grant;
  logic [6:0] o_Counter;
  logic       o_Blank;
  logic       o_Busy;

  int n_checks = 0;
  int n_fail   = 0;

  display_scheduler #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .BLINK_HALF (BH)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Req    (i_Req),
    .i_Value0 (i_Value0),
    .i_Value1 (i_Value1),
    .i_Value2 (i_Value2),
    .i_Blink  (i_Blink),
    .o_Grant  (o_Grant),
    .o_Counter(o_Counter),
    .o_Blank  (o_Blank),
    .o_Busy   (o_Busy)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: who owns the display, for how long, and the blink time.
  int m_owner;     // -1 when nobody owns the display
  int m_last;
  int m_age;       // cycles since the grant, capped at HOLD-1
  bit m_in_gap;
  int m_gap_idx;
  int m_counter;
  bit m_blink_on;
  int m_blink_t;   // cycles since the current blink phase started

  function automatic bit bit_of(input logic [2:0] v, input int j);
    return ((v >> j) & 3'b001) != 3'b000;
  endfunction

  function automatic int val_of(input int i);
    case (i)
      0:       return int'(i_Value0);
      1:       return int'(i_Value1);
      default: return int'(i_Value2);
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_last     = 2;
    m_age      = 0;
    m_in_gap   = 1'b0;
    m_gap_idx  = 0;
    m_counter  = 0;
    m_blink_on = 1'b0;
    m_blink_t  = 0;
  endtask

  task automatic model_grant();
    for (int k = 1; k <= 3; k++) begin
      if (m_owner < 0 && bit_of(i_Req, (m_last + k) % 3)) m_owner = (m_last + k) % 3;
    end
    if (m_owner >= 0) begin
      m_last     = m_owner;
      m_age      = 0;
      m_counter  = sat(val_of(m_owner));
      m_blink_on = bit_of(i_Blink, m_owner);
      m_blink_t  = 0;
    end
  endtask

  task automatic model_step();
    bit others;
    if (m_owner >= 0) begin
      others = 1'b0;
      for (int j = 0; j < 3; j++) if (j != m_owner && bit_of(i_Req, j)) others = 1'b1;
      if (m_age == HOLD - 1 && others) begin
        m_owner   = -1;
        m_in_gap  = 1'b1;
        m_gap_idx = 0;
      end else if (m_age == HOLD - 1 && !bit_of(i_Req, m_owner)) begin
        m_owner = -1;
      end else begin
        if (m_age < HOLD - 1) m_age++;
        if (bit_of(i_Req, m_owner)) m_counter = sat(val_of(m_owner));
        if (bit_of(i_Blink, m_owner) != m_blink_on) begin
          m_blink_on = bit_of(i_Blink, m_owner);
          m_blink_t  = 0;
        end else begin
          m_blink_t++;
        end
      end
    end else if (m_in_gap) begin
      if (m_gap_idx == GAP - 1) begin
        m_in_gap = 1'b0;
        model_grant();
      end else begin
        m_gap_idx++;
      end
    end else begin
      model_grant();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int e_grant, e_blank, e_busy;
    e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    e_blank = (m_owner < 0) ? 1 : (m_blink_on ? ((m_blink_t / BH) % 2) : 0);
    e_busy  = (m_owner >= 0 || m_in_gap) ? 1 : 0;
    chk("grant",   32'(o_Grant),   32'(e_grant));
    chk("counter", 32'(o_Counter), 32'(m_counter));
    chk("blank",   32'(o_Blank),   32'(e_blank));
    chk("busy",    32'(o_Busy),    32'(e_busy));
  endtask

  task automatic do_cycle();
    @(posedge i_Clk);
    if (i_Rst_n) model_step();
    else         model_reset();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    bit found;
    i_Rst_n  = 1'b0;
    i_Req    = '0;
    i_Blink  = '0;
    i_Value0 = '0;
    i_Value1 = '0;
    i_Value2 = '0;
    model_reset();

    // Reset and quiet idle
    run(2);
    i_Rst_n = 1'b1;
    run(5);

    // Single request, then saturation
    i_Req = 3'b001; i_Value0 = 7'd42;
    do_cycle();
    chk("s2_grant", 32'(o_Grant), 32'd1);
    chk("s2_value", 32'(o_Counter), 32'd42);
    i_Value0 = 7'd120;
    do_cycle();
    chk("s2_sat", 32'(o_Counter), 32'd99);
    i_Req = 3'b000;
    run(12);

    // Early drop: value frozen until the hold time ends
    i_Req = 3'b001; i_Value0 = 7'd7;
    run(2);
    i_Req = 3'b000; i_Value0 = 7'd50;
    run(10);
    chk("s4_frozen", 32'(o_Counter), 32'd7);

    // All three requesting: full round-robin rotation
    i_Req = 3'b111; i_Value0 = 7'd11; i_Value1 = 7'd22; i_Value2 = 7'd127;
    run(42);
    i_Req = 3'b000;
    run(12);

    // Blink on requester 1
    i_Req = 3'b010; i_Blink = 3'b010;
    run(14);
    i_Blink = 3'b000;
    run(3);
    i_Blink = 3'b010;
    run(5);
    i_Req = 3'b000; i_Blink = 3'b000;
    run(12);

    // Single-cycle pulse from requester 1 at the owner's expiry, twice
    for (int pass = 0; pass < 2; pass++) begin
      i_Req = 3'b001; i_Value0 = 7'd5; i_Value1 = 7'd66;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        do_cycle();
        if (m_owner == 0 && m_age == HOLD - 1) found = 1'b1;
      end
      chk("s6_expiry_seen", 32'(found), 32'd1);
      i_Req = 3'b011;
      do_cycle();
      i_Req = (pass == 0) ? 3'b001 : 3'b011;
      run(6);
      chk("s6_regrant", 32'(o_Grant), (pass == 0) ? 32'd1 : 32'd2);
      i_Req = 3'b000;
      run(12);
    end

    // Asynchronous reset in the middle of a show
    i_Req = 3'b100; i_Value2 = 7'd33;
    run(3);
    i_Rst_n = 1'b0;
    #1;
    chk("arst_grant",   32'(o_Grant),   32'd0);
    chk("arst_counter", 32'(o_Counter), 32'd0);
    chk("arst_blank",   32'(o_Blank),   32'd1);
    chk("arst_busy",    32'(o_Busy),    32'd0);
    model_reset();
    do_cycle();
    i_Rst_n = 1'b1;
    run(12);
    i_Req = 3'b000;
    run(12);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) i_Req = 3'($urandom_range(7));
      if ($urandom_range(1) == 0) begin
        i_Value0 = 7'($urandom_range(127));
        i_Value1 = 7'($urandom_range(127));
        i_Value2 = 7'($urandom_range(127));
      end
      if ($urandom_range(15) == 0) i_Blink = 3'($urandom_range(7));
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the single two-digit 7-segment display between three requesters: game score, level number and status/timer.
- Decides which requester owns the display and for how long, inserts a blank gap between owners, and supports blinking.
- Drives the 7-bit counter value (0..99) and a blank flag into the segment decoder.
- Sits between game-control logic and the segment decoder; all timing is in i_Clk cycles.

Parameters:
- HOLD_CYCLES, 25_000_000: minimum cycles a granted requester keeps the display (1 s at 25 MHz); must be >= 1.
- GAP_CYCLES, 2_500_000: blank cycles inserted when ownership changes; must be >= 1.
- BLINK_HALF, 6_250_000: half-period, in cycles, of the blink toggle; must be >= 1.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req  in  3  per-requester display request, level sensitive.
- i_Value0  in  7  value from requester 0.
- i_Value1  in  7  value from requester 1.
- i_Value2  in  7  value from requester 2.
- i_Blink  in  3  per-requester blink enable.
- o_Grant  out  3  one-hot current owner; all zero when none.
- o_Counter  out  7  value to the decoder, 0..99.
- o_Blank  out  1  1 = decoder output forced off.
- o_Busy  out  1  1 when state != IDLE.

Behaviour:
- Clock, reset and outputs
  - One clock and one reset; reset is asynchronous and active-low.
  - All outputs are registered.
  - Reset state: state=IDLE, o_Grant=000, o_Counter=0, o_Blank=1, o_Busy=0, hold/gap/blink counters=0, last-grant pointer=2 (so requester 0 wins first).
  - Reset asserted mid-operation clears everything immediately.
- Arbitration is round-robin: search order starts at (last+1) mod 3 and wraps; the winner becomes the new last.
- IDLE
  - o_Blank=1, o_Grant=000.
  - If any i_Req bit is set at an edge, the next cycle is SHOW: o_Grant = winner, hold counter=0, blink phase=visible.
  - Latency from request to grant is one cycle.
- SHOW, value path
  - While i_Req[g] is high, o_Counter <= min(i_Value[g], 99), updated every cycle.
  - Values 100..127 saturate to 99.
  - If i_Req[g] drops, o_Counter freezes at its last value.
- SHOW, hold counter
  - Increments each cycle and saturates at HOLD_CYCLES-1; "expired" means count == HOLD_CYCLES-1.
  - Before expiry the owner is never preempted, even if it drops its request.
- SHOW, blink
  - If i_Blink[g]=1, o_Blank toggles every BLINK_HALF cycles, starting at 0.
  - Otherwise o_Blank=0.
  - Changing i_Blink mid-show takes effect on the next cycle and resets the phase to visible.
- SHOW, at expiry (evaluated every cycle after expiry)
  - Another requester pending, whether or not the owner still requests: go to GAP; o_Grant=000, o_Blank=1, gap counter=0.
  - No other requester pending and owner still requesting: stay in SHOW; the hold counter stays saturated.
  - No requester pending at all: go to IDLE.
- GAP
  - Blank for exactly GAP_CYCLES cycles.
  - On the last gap cycle, arbitrate over the current i_Req: any set goes to SHOW with the round-robin winner; none set goes to IDLE.
  - The winner may be the previous owner if it is the only one still requesting.
- Simultaneous events
  - Owner drop plus another request at the expiry cycle goes to GAP.
  - Multiple requests in IDLE are resolved by the round-robin pointer.
  - o_Grant is never more than one-hot.

Test Plan:
All scenarios use HOLD_CYCLES=8, GAP_CYCLES=2, BLINK_HALF=3.
1. Reset: hold i_Rst_n=0, then release with i_Req=000 -> o_Grant=000, o_Counter=0, o_Blank=1, o_Busy=0 indefinitely; assert i_Rst_n=0 mid-SHOW -> outputs return to reset values before the next edge.
2. Single request and saturation: i_Req=001, i_Value0=42 -> one cycle later o_Grant=001, o_Counter=42, o_Blank=0; change i_Value0 to 120 -> o_Counter=99 next cycle.
3. Hold and round-robin: i_Req=111 from IDLE -> grant 001 for 8 cycles, blank 2 cycles, grant 010 for 8, gap 2, grant 100, gap 2, grant 001 again.
4. Early drop: i_Req=001 (value 7), drop after 2 cycles -> o_Counter stays 7, o_Blank=0 until the 8th SHOW cycle, then IDLE with o_Blank=1.
5. Blink: i_Req=010, i_Blink=010 -> o_Blank pattern 0,0,0,1,1,1,0... starting at the grant cycle; o_Grant stays 010.
6. Sole re-winner: owner 0 keeps requesting and requester 1 pulses once at expiry -> GAP, then re-grant; the winner is 010 if i_Req[1] is still set, else 001.
